uart_tx_sched: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit scheduler
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } sched_state_t;

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = grant_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [GW-1:0] gnt_id,
    output logic          any
);

    logic [GW-1:0] w_sel;

    // Walk the requesters from ptr upward with wrap-around; first active one wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        w_sel  = '0;
        for (int k = 0; k < N; k++) begin
            w_sel = GW'((int'(ptr) + k) % N);
            if (!any && req[w_sel]) begin
                any        = 1'b1;
                gnt[w_sel] = 1'b1;
                gnt_id     = w_sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler feeding one UART transmitter
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_BITS = DEFAULT_DATA_BITS,
    parameter int  MAX_BURST = 16,
    parameter int  STALL_MAX = 255,
    localparam int GRANT_W   = grant_w(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [GRANT_W-1:0]           grant_id,
    output logic                         busy,
    output logic                         stall_abort
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX - 1);

    sched_state_t           r_state;
    sched_state_t           w_next;
    logic [GRANT_W-1:0]     r_ptr;
    logic [GRANT_W-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_gnt_oh;
    logic [BURST_W-1:0]     r_burst;
    logic [STALL_W-1:0]     r_stall;
    logic [DATA_BITS-1:0]   r_tx_data;
    logic                   r_tx_valid;
    logic                   r_last;

    logic [NUM_REQ-1:0]     w_arb_gnt;
    logic [GRANT_W-1:0]     w_arb_id;
    logic                   w_arb_any;
    logic                   w_grantee_valid;
    logic                   w_grantee_last;
    logic [DATA_BITS-1:0]   w_grantee_data;
    logic                   w_tx_acc;
    logic                   w_end_grant;
    logic [GRANT_W-1:0]     w_ptr_next;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic                   w_stall_hit;

    rr_arbiter #(
        .N  (NUM_REQ),
        .GW (GRANT_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_ptr),
        .gnt    (w_arb_gnt),
        .gnt_id (w_arb_id),
        .any    (w_arb_any)
    );

    assign w_grantee_valid = |(req_valid & r_gnt_oh);
    assign w_grantee_last  = |(req_last & r_gnt_oh);
    assign w_tx_acc        = r_tx_valid & tx_ready;
    assign w_end_grant     = r_last || (r_burst == BURST_LIM);
    assign w_ptr_next      = (r_grant == GRANT_W'(NUM_REQ - 1)) ? '0 : r_grant + GRANT_W'(1);

    // Select the granted requester's byte using the registered one-hot grant.
    always_comb begin
        w_grantee_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt_oh[i]) begin
                w_grantee_data = w_grantee_data | req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Next state, grantee ready decode and the stall-timeout pulse.
    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_stall_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_req_ready = r_gnt_oh;
                if (w_grantee_valid) begin
                    w_next = SEND;
                end else if (r_stall == STALL_LIM) begin
                    w_stall_hit = 1'b1;
                    w_next      = IDLE;
                end
            end
            SEND: begin
                if (w_tx_acc) begin
                    w_next = w_end_grant ? IDLE : LOAD;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant, pointer, counters and the holding register for the transmitter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_gnt_oh   <= '0;
            r_burst    <= '0;
            r_stall    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_grant  <= w_arb_id;
                        r_gnt_oh <= w_arb_gnt;
                        r_burst  <= '0;
                        r_stall  <= '0;
                    end
                end
                LOAD: begin
                    if (w_grantee_valid) begin
                        r_tx_data  <= w_grantee_data;
                        r_tx_valid <= 1'b1;
                        r_last     <= w_grantee_last;
                        r_burst    <= r_burst + 1'b1;
                        r_stall    <= '0;
                    end else begin
                        // The final increment lands on STALL_MAX and the grant is dropped.
                        r_stall <= r_stall + 1'b1;
                        if (w_stall_hit) begin
                            r_ptr   <= w_ptr_next;
                            r_burst <= '0;
                        end
                    end
                end
                SEND: begin
                    if (w_tx_acc) begin
                        r_tx_valid <= 1'b0;
                        if (w_end_grant) begin
                            r_ptr   <= w_ptr_next;
                            r_burst <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign grant_id    = r_grant;
    assign busy        = (r_state != IDLE);
    assign stall_abort = w_stall_hit;

endmodule
